// File: rtl/switch_monitor.sv
// switch_monitor: debounces a bank of slide switches and reports statistics on 7-segment digits.
//
// Each switch goes through a 2-flop synchroniser. It then goes through a stability-counter
// debouncer. The debounced state drives stled directly. The six digits show:
//   sthex1:sthex0 - number of debounced switches that are on (hex, 00..10)
//   sthex3:sthex2 - index of the most recently toggled switch, blank when none recorded
//   sthex5:sthex4 - 8-bit count of cycles with at least one toggle (wraps FF->00)
//
// Optional feature: define SWMON_EVENT_CNT_EN to build the event counter. Without it,
// sthex5:sthex4 stay blank (8'hFF) and no counter logic exists.
//
// Ports:
//   clk    - system clock, all state on the rising edge
//   rst    - asynchronous active-high reset
//   clr    - synchronous clear of the event counter and last-index record
//   stswi  - raw switch inputs, asynchronous to clk
//   stled  - debounced switch state
//   sthex0..sthex5 - active-low segment patterns {dp, g..a}; dp is always off
module switch_monitor #(
  parameter int unsigned NSW        = 16,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic [NSW-1:0] stswi,
  output logic [NSW-1:0] stled,
  output logic [7:0]     sthex0,
  output logic [7:0]     sthex1,
  output logic [7:0]     sthex2,
  output logic [7:0]     sthex3,
  output logic [7:0]     sthex4,
  output logic [7:0]     sthex5
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);
  localparam logic [7:0] SegBlank = 8'hFF;
  localparam logic [7:0] SegZero  = 8'hC0;

  // Hex digit to active-low {dp, g..a}, dp held off.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Synchroniser
  logic [NSW-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= stswi;
      sync2_q <= sync1_q;
    end
  end

  // Debounce
  logic [NSW-1:0]  deb_q, deb_d, toggle;
  logic [CntW-1:0] cnt_q [NSW];
  logic [CntW-1:0] cnt_d [NSW];

  always_comb begin
    toggle = '0;
    for (int i = 0; i < NSW; i++) begin
      toggle[i] = (sync2_q[i] != deb_q[i]) && (cnt_q[i] == CntMax);
      // Counter restarts whenever the input agrees with the output or the output just flipped.
      if ((sync2_q[i] == deb_q[i]) || toggle[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
    deb_d = deb_q ^ toggle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= '0;
      for (int i = 0; i < NSW; i++) cnt_q[i] <= '0;
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < NSW; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stled = deb_q;

  // Statistics
  logic [4:0] on_cnt;
  logic [3:0] new_idx;
  logic       any_toggle;

  always_comb begin
    on_cnt  = '0;
    new_idx = '0;
    for (int i = 0; i < NSW; i++) begin
      on_cnt = on_cnt + 5'(deb_q[i]);
      // Ascending scan so the highest simultaneous toggle wins.
      if (toggle[i]) new_idx = 4'(i);
    end
    any_toggle = |toggle;
  end

  logic       last_vld_q;
  logic [3:0] last_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_vld_q <= 1'b0;
      last_idx_q <= '0;
    end else if (clr) begin
      last_vld_q <= 1'b0;
    end else if (any_toggle) begin
      last_vld_q <= 1'b1;
      last_idx_q <= new_idx;
    end
  end

  // Segment registers for the always-present digits
  logic [7:0] hex0_q, hex1_q, hex2_q, hex3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex0_q <= SegZero;
      hex1_q <= SegZero;
      hex2_q <= SegBlank;
      hex3_q <= SegBlank;
    end else begin
      hex0_q <= seg7(on_cnt[3:0]);
      hex1_q <= seg7({3'b000, on_cnt[4]});
      hex2_q <= last_vld_q ? seg7(last_idx_q) : SegBlank;
      hex3_q <= last_vld_q ? SegZero : SegBlank;
    end
  end

  assign sthex0 = hex0_q;
  assign sthex1 = hex1_q;
  assign sthex2 = hex2_q;
  assign sthex3 = hex3_q;

`ifdef SWMON_EVENT_CNT_EN
  logic [7:0] evt_q;
  logic [7:0] hex4_q, hex5_q;

  // clr takes priority, so a toggle in the clr cycle is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_q <= '0;
    end else if (clr) begin
      evt_q <= '0;
    end else if (any_toggle) begin
      evt_q <= evt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex4_q <= SegZero;
      hex5_q <= SegZero;
    end else begin
      hex4_q <= seg7(evt_q[3:0]);
      hex5_q <= seg7(evt_q[7:4]);
    end
  end

  assign sthex4 = hex4_q;
  assign sthex5 = hex5_q;
`else
  assign sthex4 = SegBlank;
  assign sthex5 = SegBlank;
`endif

endmodule

// File: tb/tb_switch_monitor.sv
// Directed testbench for switch_monitor with NSW=16 and DEB_CYCLES=4.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the same point.
// Event-counter digits are expected blank when SWMON_EVENT_CNT_EN is not defined.
module tb_switch_monitor;

  localparam logic [7:0] S0 = 8'hC0, S1 = 8'hF9, S2 = 8'hA4, S3 = 8'hB0, S4 = 8'h99;
  localparam logic [7:0] S5 = 8'h92, S9 = 8'h90, SF = 8'h8E, BL = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [15:0] stswi;
  logic [15:0] stled;
  logic [7:0]  sthex0, sthex1, sthex2, sthex3, sthex4, sthex5;

  int n_assert = 0;
  int n_fail   = 0;

  switch_monitor #(
    .NSW       (16),
    .DEB_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .stswi (stswi),
    .stled (stled),
    .sthex0(sthex0),
    .sthex1(sthex1),
    .sthex2(sthex2),
    .sthex3(sthex3),
    .sthex4(sthex4),
    .sthex5(sthex5)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic [7:0] hi, input logic [7:0] lo);
`ifdef SWMON_EVENT_CNT_EN
    chk({tag, ".hex5"}, {8'h00, sthex5}, {8'h00, hi});
    chk({tag, ".hex4"}, {8'h00, sthex4}, {8'h00, lo});
`else
    chk({tag, ".hex5"}, {8'h00, sthex5}, {8'h00, BL});
    chk({tag, ".hex4"}, {8'h00, sthex4}, {8'h00, BL});
`endif
  endtask

  task automatic chk_disp(input string tag, input logic [7:0] h1, input logic [7:0] h0,
                          input logic [7:0] h3, input logic [7:0] h2);
    chk({tag, ".hex1"}, {8'h00, sthex1}, {8'h00, h1});
    chk({tag, ".hex0"}, {8'h00, sthex0}, {8'h00, h0});
    chk({tag, ".hex3"}, {8'h00, sthex3}, {8'h00, h3});
    chk({tag, ".hex2"}, {8'h00, sthex2}, {8'h00, h2});
  endtask

  initial begin
    rst   = 1'b1;
    clr   = 1'b0;
    stswi = '0;
    tick(2);
    chk("rst.stled", stled, 16'h0000);
    chk_disp("rst", S0, S0, BL, BL);
    chk_evt("rst", S0, S0);

    rst = 1'b0;
    tick(2);
    chk("idle.stled", stled, 16'h0000);
    chk_disp("idle", S0, S0, BL, BL);
    chk_evt("idle", S0, S0);

    // Clean rise on switch 5: visible exactly 6 edges later.
    stswi[5] = 1'b1;
    tick(5);
    chk("sw5.early", stled, 16'h0000);
    tick(1);
    chk("sw5.stled", stled, 16'h0020);
    chk("sw5.hexlag", {8'h00, sthex0}, {8'h00, S0});
    tick(1);
    chk_disp("sw5", S0, S1, S0, S5);
    chk_evt("sw5", S0, S1);

    // 3-cycle glitch on switch 3 must be filtered out.
    stswi[3] = 1'b1;
    tick(3);
    stswi[3] = 1'b0;
    tick(8);
    chk("glitch.stled", stled, 16'h0020);
    chk_disp("glitch", S0, S1, S0, S5);
    chk_evt("glitch", S0, S1);

    // A 4-cycle pulse is just long enough; the release then debounces back down.
    stswi[3] = 1'b1;
    tick(4);
    stswi[3] = 1'b0;
    tick(2);
    chk("pulse4.rise", stled, 16'h0028);
    tick(1);
    chk_disp("pulse4.rise", S0, S2, S0, S3);
    chk_evt("pulse4.rise", S0, S2);
    tick(3);
    chk("pulse4.fall", stled, 16'h0020);
    tick(1);
    chk_disp("pulse4.fall", S0, S1, S0, S3);
    chk_evt("pulse4.fall", S0, S3);

    // Simultaneous rise on 2 and 9: one event, highest index recorded.
    stswi[2] = 1'b1;
    stswi[9] = 1'b1;
    tick(6);
    chk("pair.stled", stled, 16'h0224);
    tick(1);
    chk_disp("pair", S0, S3, S0, S9);
    chk_evt("pair", S0, S4);

    // clr on the cycle switch 0 toggles: stled still updates, stats cleared.
    stswi[0] = 1'b1;
    tick(5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr.stled", stled, 16'h0225);
    tick(1);
    chk_disp("clr", S0, S4, BL, BL);
    chk_evt("clr", S0, S0);

    // 255 then 256 toggles of switch 15: counter reaches FF, then wraps to 00.
    for (int k = 0; k < 255; k++) begin
      stswi[15] = ~stswi[15];
      tick(7);
    end
    chk("wrap255.stled", stled, 16'h8225);
    chk_disp("wrap255", S0, S5, S0, SF);
    chk_evt("wrap255", SF, SF);
    stswi[15] = ~stswi[15];
    tick(7);
    chk("wrap256.stled", stled, 16'h0225);
    chk_disp("wrap256", S0, S4, S0, SF);
    chk_evt("wrap256", S0, S0);

    // Reset in the middle of debouncing switch 1; held switches re-debounce afterwards.
    stswi[1] = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    chk("midrst.async", stled, 16'h0000);
    tick(1);
    chk_disp("midrst", S0, S0, BL, BL);
    chk_evt("midrst", S0, S0);
    rst = 1'b0;
    tick(5);
    chk("redeb.early", stled, 16'h0000);
    tick(1);
    chk("redeb.stled", stled, 16'h0227);
    tick(1);
    chk_disp("redeb", S0, S5, S0, S9);
    chk_evt("redeb", S0, S1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_monitor.md
SWITCH_MONITOR -- requirements
Module: switch_monitor

Interface
REQ-001 Parameter NSW, default 16: number of slide switches/LEDs, legal 1..16.
REQ-002 Parameter DEB_CYCLES, default 500000: debounce stability window in clk cycles, legal 2..2^20.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous clear of event statistics, sampled each clk.
REQ-006 stswi  input  NSW  raw slide switches, asynchronous to clk.
REQ-007 stled  output  NSW  debounced switch state, registered.
REQ-008 sthex0..sthex5  output  8 each  7-seg patterns, bit7=dp, bits6:0=g..a, active-low, blank=8'hFF, dp always off.

Function
REQ-009 Each stswi bit SHALL pass a 2-flop synchroniser before any other use.
REQ-010 Per switch, a stability counter SHALL clear whenever the synchronised value equals the debounced value, else increment.
REQ-011 Debounced bit SHALL flip, and its counter clear, on the edge where the counter equals DEB_CYCLES-1 and values still differ.
REQ-012 Latency: a clean stswi change SHALL appear on stled exactly 2+DEB_CYCLES clk cycles later; glitches shorter than DEB_CYCLES cycles SHALL never reach stled.
REQ-013 A toggle event SHALL be the cycle a debounced bit flips; one-cycle internal pulse per switch.
REQ-014 ON count = number of debounced bits at 1; sthex1:sthex0 SHALL show it as two hex digits (00..10), updated the cycle after stled changes.
REQ-015 Last index SHALL record the switch number of the most recent toggle event; several toggles in one cycle record the highest-numbered switch.
REQ-016 sthex3:sthex2 SHALL show last index as two hex digits, or blank both when no event recorded since reset/clr.
REQ-017 Event counter, 8 bits, SHALL increment by exactly 1 per cycle having at least one toggle event, wrapping FF->00.
REQ-018 sthex5:sthex4 SHALL show the event counter as two hex digits.
REQ-019 clr high SHALL zero the event counter and set last index to "none" on the next edge; clr SHALL NOT affect debounce state, stled or ON count.
REQ-020 clr and toggle event in the same cycle: clr wins, event discarded.
REQ-021 Segment outputs SHALL be registered, one cycle after the value they display.
REQ-022 Switch bits at index >= NSW do not exist; no logic SHALL depend on them.

Reset
REQ-023 On rst: synchronisers, debounced state, stability counters, event counter = 0; last index = none.
REQ-024 During/after rst: stled=0, sthex0=sthex1=sthex4=sthex5 show '0', sthex2=sthex3=8'hFF.
REQ-025 rst asserted mid-debounce SHALL discard the partial count; switches held on through reset SHALL debounce afresh and count as toggle events.

Configuration
REQ-026 Macro SWMON_EVENT_CNT_EN defined: event counter and sthex5:sthex4 per REQ-017/018.
REQ-027 Macro SWMON_EVENT_CNT_EN undefined: event counter not synthesised, sthex4 and sthex5 constant 8'hFF; all other behaviour unchanged.

Verification (NSW=16, DEB_CYCLES=4, macro defined unless stated)
REQ-028 Reset release, stswi=0 -> stled=0, sthex1:0 "00", sthex3:2 blank, sthex5:4 "00".
REQ-029 stswi[5] 0->1 held -> stled[5]=1 exactly 6 cycles later; sthex1:0 "01", sthex3:2 "05", sthex5:4 "01" one cycle after that.
REQ-030 stswi[3] pulsed high 3 cycles -> stled unchanged, counter unchanged; pulse of 4 cycles -> stled[3] rises.
REQ-031 stswi[2] and stswi[9] rise same cycle -> both debounce same edge; last index "09", event counter +1 only.
REQ-032 clr asserted on the cycle of a toggle event -> event counter 00, sthex3:2 blank, stled still updated; 256 events from 00 -> counter wraps to 00.
REQ-033 Macro undefined, any stimulus -> sthex4=sthex5=8'hFF always; other outputs as with macro.
